// File: rtl/vend_payout_if.sv
// Signal bundle between the coin controller / mechanics and vend_payout_unit.
// The unit attaches through the slave modport; the controller side uses master.
interface vend_payout_if #(
    parameter int CHANGE_W = 2
);
    logic                vend_req;
    logic [CHANGE_W-1:0] change_in;
    logic                motor_done;
    logic                hopper_ack;
    logic                clear_err;
    logic                motor_on;
    logic                hopper_pulse;
    logic                busy;
    logic                done;
    logic                jam_err;
    logic [CHANGE_W-1:0] coins_paid;
    logic [15:0]         total_paid;

    modport master (
        output vend_req,
        output change_in,
        output motor_done,
        output hopper_ack,
        output clear_err,
        input  motor_on,
        input  hopper_pulse,
        input  busy,
        input  done,
        input  jam_err,
        input  coins_paid,
        input  total_paid
    );

    modport slave (
        input  vend_req,
        input  change_in,
        input  motor_done,
        input  hopper_ack,
        input  clear_err,
        output motor_on,
        output hopper_pulse,
        output busy,
        output done,
        output jam_err,
        output coins_paid,
        output total_paid
    );
endinterface

// File: rtl/vend_payout_unit.sv
// Vend back end: runs the product motor, pays change coin by coin with jam retry.
// Define PAYOUT_STATS_EN to build the lifetime total_paid coin counter.
module vend_payout_unit #(
    parameter int CHANGE_W      = 2,
    parameter int PULSE_CYCLES  = 4,
    parameter int ACK_TIMEOUT   = 16,
    parameter int MOTOR_TIMEOUT = 64,
    parameter int MAX_RETRY     = 1
) (
    input  logic          clk,
    input  logic          reset,
    vend_payout_if.slave  bus
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_VEND      = 3'd1;
    localparam logic [2:0] ST_PAY_PULSE = 3'd2;
    localparam logic [2:0] ST_PAY_WAIT  = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;
    localparam logic [2:0] ST_ERROR     = 3'd5;

    localparam int TIMER_MAX_A = (MOTOR_TIMEOUT > ACK_TIMEOUT) ? MOTOR_TIMEOUT : ACK_TIMEOUT;
    localparam int TIMER_MAX   = (TIMER_MAX_A > PULSE_CYCLES) ? TIMER_MAX_A : PULSE_CYCLES;
    localparam int TIMER_W     = $clog2(TIMER_MAX + 1);
    localparam int RETRY_W     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TIMER_W-1:0] MOTOR_LAST = TIMER_W'(MOTOR_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] ACK_LAST   = TIMER_W'(ACK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] PULSE_LAST = TIMER_W'(PULSE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM  = RETRY_W'(MAX_RETRY);

    logic [2:0]          state, state_n;
    logic [TIMER_W-1:0]  timer, timer_n;
    logic [CHANGE_W-1:0] remaining, remaining_n;
    logic [CHANGE_W-1:0] coins, coins_n;
    logic [RETRY_W-1:0]  retry, retry_n;

    logic motor_on_q;
    logic hopper_pulse_q;
    logic busy_q;
    logic done_q;
    logic jam_err_q;

    function automatic logic [CHANGE_W-1:0] sat_inc(input logic [CHANGE_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CHANGE_W'(1);
    endfunction

    always_comb begin
        state_n     = state;
        timer_n     = timer;
        remaining_n = remaining;
        coins_n     = coins;
        retry_n     = retry;
        case (state)
            ST_IDLE: begin
                if (bus.vend_req) begin
                    state_n     = ST_VEND;
                    remaining_n = bus.change_in;
                    coins_n     = '0;
                    timer_n     = '0;
                    retry_n     = '0;
                end
            end
            ST_VEND: begin
                // A drop reported in the timeout cycle still counts as success.
                if (bus.motor_done) begin
                    timer_n = '0;
                    state_n = (remaining != '0) ? ST_PAY_PULSE : ST_DONE;
                end else if (timer == MOTOR_LAST) begin
                    state_n = ST_ERROR;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            ST_PAY_PULSE: begin
                if (timer == PULSE_LAST) begin
                    timer_n = '0;
                    state_n = ST_PAY_WAIT;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            ST_PAY_WAIT: begin
                if (bus.hopper_ack) begin
                    coins_n     = sat_inc(coins);
                    remaining_n = remaining - CHANGE_W'(1);
                    retry_n     = '0;
                    timer_n     = '0;
                    state_n     = (remaining == CHANGE_W'(1)) ? ST_DONE : ST_PAY_PULSE;
                end else if (timer == ACK_LAST) begin
                    timer_n = '0;
                    if (retry < RETRY_LIM) begin
                        retry_n = retry + 1'b1;
                        state_n = ST_PAY_PULSE;
                    end else begin
                        state_n = ST_ERROR;
                    end
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            ST_ERROR: begin
                if (bus.clear_err) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n     = ST_IDLE;
                timer_n     = '0;
                remaining_n = '0;
                retry_n     = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change with the state itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            timer          <= '0;
            remaining      <= '0;
            coins          <= '0;
            retry          <= '0;
            motor_on_q     <= 1'b0;
            hopper_pulse_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            jam_err_q      <= 1'b0;
        end else begin
            state          <= state_n;
            timer          <= timer_n;
            remaining      <= remaining_n;
            coins          <= coins_n;
            retry          <= retry_n;
            motor_on_q     <= (state_n == ST_VEND);
            hopper_pulse_q <= (state_n == ST_PAY_PULSE);
            busy_q         <= (state_n != ST_IDLE);
            done_q         <= (state_n == ST_DONE);
            jam_err_q      <= (state_n == ST_ERROR);
        end
    end

    assign bus.motor_on     = motor_on_q;
    assign bus.hopper_pulse = hopper_pulse_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.jam_err      = jam_err_q;
    assign bus.coins_paid   = coins;

`ifdef PAYOUT_STATS_EN
    logic [15:0] total_q;

    // Survives clear_err; only reset zeroes the lifetime count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            total_q <= '0;
        end else if (state == ST_PAY_WAIT && bus.hopper_ack) begin
            total_q <= total_q + 16'd1;
        end
    end

    assign bus.total_paid = total_q;
`else
    assign bus.total_paid = '0;
`endif

endmodule

// File: doc/vend_payout_unit.md
Name: vend_payout_unit

Overview:
Mechanical back end of the coin vending path. It accepts a one-cycle vend command plus a change amount from the coin-accepting controller. It then runs the product motor and pays change one coin at a time through a pulsed hopper, checking each coin against an exit sensor. Jams and motor stalls are detected with timeouts, and the unit reports completion or a sticky error back to the controller.

Parameters:
CHANGE_W, 2, width of change_in and coins_paid
PULSE_CYCLES, 4, hopper_pulse high time per coin (>=1)
ACK_TIMEOUT, 16, cycles to wait in PAY_WAIT for hopper_ack before one retry
MOTOR_TIMEOUT, 64, max cycles in VEND waiting for motor_done
MAX_RETRY, 1, re-pulses allowed per coin before declaring a jam

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
vend_req  input  1  one-cycle vend command; sampled only in IDLE
change_in  input  CHANGE_W  coins of change to pay; latched with vend_req
motor_done  input  1  product-dropped sensor, level
hopper_ack  input  1  coin-exit sensor, one-cycle pulse per coin
clear_err  input  1  clears ERROR, returns to IDLE
motor_on  output  1  product motor drive
hopper_pulse  output  1  coin hopper solenoid drive
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on successful completion
jam_err  output  1  sticky error flag, high in ERROR
coins_paid  output  CHANGE_W  coins confirmed for the current or last transaction
total_paid  output  16  lifetime coins paid (see Optional Feature)

Behaviour:
- Reset (async, active-high): state=IDLE; all outputs 0; internal counters 0. Reset mid-operation drops motor_on and hopper_pulse immediately.
- All outputs are registered and derived from state and counters. No combinational path from any input to any output.
- IDLE:
  - vend_req=1 latches change_in into remaining, clears coins_paid and the timer, then moves to VEND.
  - motor_on rises the cycle after vend_req is sampled.
  - vend_req outside IDLE is ignored and not queued.
- VEND:
  - motor_on=1; timer increments each cycle.
  - motor_done=1 drops motor_on next cycle. Goes to PAY_PULSE if remaining!=0, otherwise to DONE.
  - If the timer reaches MOTOR_TIMEOUT-1 without motor_done, goes to ERROR. motor_done in that same cycle wins.
- PAY_PULSE:
  - hopper_pulse=1 for exactly PULSE_CYCLES cycles, then PAY_WAIT with timer=0.
  - hopper_ack during PAY_PULSE is ignored.
- PAY_WAIT:
  - hopper_pulse=0.
  - hopper_ack=1: coins_paid+1, remaining-1, retry count cleared. Goes to DONE if remaining becomes 0, else PAY_PULSE.
  - If the timer reaches ACK_TIMEOUT-1 with no ack: re-pulse (PAY_PULSE) if retries<MAX_RETRY, else ERROR.
  - hopper_ack in the timeout cycle counts as success.
- DONE: done=1 for one cycle, then IDLE. busy is still high in DONE.
- ERROR:
  - jam_err=1, motor_on=0, hopper_pulse=0. coins_paid holds the value reached.
  - clear_err=1 goes to IDLE and clears jam_err next cycle. vend_req is ignored until then.
- Arithmetic and encoding:
  - coins_paid saturates at 2^CHANGE_W-1; it cannot exceed change_in by construction.
  - The timer is sized for max(MOTOR_TIMEOUT, ACK_TIMEOUT) and does not wrap.
  - Undefined state encodings go to IDLE.

Optional Feature:
PAYOUT_STATS_EN
- Defined: total_paid is a 16-bit counter that increments on every accepted hopper_ack and wraps 0xFFFF->0. It is cleared only by reset; clear_err does not affect it.
- Undefined: total_paid is tied to 0 and no counter logic is built.

Test Plan:
- Normal vend, no change: reset, then vend_req with change_in=0; motor_done after 5 cycles -> motor_on high 5 cycles, no hopper_pulse, done pulses once, coins_paid=0, busy returns low.
- Vend with 1 coin change: change_in=1; motor_done after 3 cycles; hopper_ack 2 cycles after the pulse falls -> one 4-cycle hopper_pulse, coins_paid=1, done=1 once.
- Jam with retry: change_in=1, hopper_ack never asserted -> two 4-cycle pulses spaced by 16 idle cycles, then jam_err=1 and coins_paid=0. clear_err -> IDLE and jam_err=0.
- Motor stall: vend_req, no motor_done -> motor_on high exactly 64 cycles, then jam_err=1 with no hopper activity.
- Ignored request and async reset: vend_req pulsed mid-VEND -> no second transaction. Assert reset during a PAY_PULSE -> hopper_pulse, busy and jam_err are 0 immediately.
- Stats (PAYOUT_STATS_EN): three transactions with change 1, 2, 0 -> total_paid=3. A jam in between does not increment it.
